// File: rtl/counter_pkg.sv
// Shared constants, limit-mode enum and load clamp helper for multi_mode_counter.
package counter_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    typedef enum logic {
        LIM_WRAP = 1'b0,
        LIM_SAT  = 1'b1
    } lim_mode_e;

    function automatic logic [31:0] clamp_load(
        input logic [31:0] val,
        input logic [31:0] max
    );
        return (val > max) ? max : val;
    endfunction

endpackage

// File: rtl/counter_channel.sv
// One counter channel: load > enable > hold, wrap or saturate at [0, MAX_VAL].
module counter_channel
    import counter_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int MAX_VAL = 255,
    parameter int RST_VAL = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             dir,
    input  logic             sat,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tc
);

    localparam logic [WIDTH:0]   MAX_EXT = (WIDTH+1)'(MAX_VAL);
    localparam logic [WIDTH-1:0] MAX_W   = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] RST_W   = WIDTH'(RST_VAL);

    logic [WIDTH-1:0] r_count;
    logic             r_tc;
    logic [WIDTH:0]   w_inc;
    logic [WIDTH-1:0] w_load;
    logic [WIDTH-1:0] w_next;
    logic             w_tc_next;
    logic             w_step;
    logic             w_at_top;
    logic             w_at_bot;
    lim_mode_e        w_mode;

    // One extra bit so MAX_VAL = 2**WIDTH-1 is still detected as the top.
    assign w_inc    = {1'b0, r_count} + (WIDTH+1)'(1);
    assign w_at_top = w_inc > MAX_EXT;
    assign w_at_bot = r_count == '0;
    assign w_load   = WIDTH'(clamp_load(32'(load_val), 32'(MAX_VAL)));
    assign w_step   = en & ~load;
    assign w_mode   = sat ? LIM_SAT : LIM_WRAP;

    always_comb begin
        w_next    = r_count;
        w_tc_next = 1'b0;
        unique case (1'b1)
            load: w_next = w_load;
            w_step && dir == DIR_UP && !w_at_top:
                w_next = w_inc[WIDTH-1:0];
            w_step && dir == DIR_UP && w_at_top: begin
                w_tc_next = 1'b1;
                if (w_mode == LIM_WRAP) w_next = '0;
            end
            w_step && dir == DIR_DOWN && !w_at_bot:
                w_next = r_count - WIDTH'(1);
            w_step && dir == DIR_DOWN && w_at_bot: begin
                w_tc_next = 1'b1;
                if (w_mode == LIM_WRAP) w_next = MAX_W;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= RST_W;
            r_tc    <= 1'b0;
        end else begin
            r_count <= w_next;
            r_tc    <= w_tc_next;
        end
    end

    assign count = r_count;
    assign tc    = r_tc;

endmodule

// File: rtl/multi_mode_counter.sv
// N-channel up/down wrap/saturate counter with terminal-count pulses.
// Optional snapshot capture port set enabled by COUNTER_SNAPSHOT_EN.
module multi_mode_counter
    import counter_pkg::*;
#(
    parameter int N_CH    = 2,
    parameter int WIDTH   = 8,
    parameter int MAX_VAL = 255,
    parameter int RST_VAL = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N_CH-1:0]       en,
    input  logic [N_CH-1:0]       dir,
    input  logic [N_CH-1:0]       sat,
    input  logic [N_CH-1:0]       load,
    input  logic [N_CH*WIDTH-1:0] load_val,
    output logic [N_CH*WIDTH-1:0] count,
    output logic [N_CH-1:0]       tc
`ifdef COUNTER_SNAPSHOT_EN
    ,
    input  logic                  snap,
    output logic [N_CH*WIDTH-1:0] snap_count,
    output logic                  snap_valid
`endif
);

    logic [N_CH*WIDTH-1:0] w_count;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        counter_channel #(
            .WIDTH   (WIDTH),
            .MAX_VAL (MAX_VAL),
            .RST_VAL (RST_VAL)
        ) u_ch (
            .clk      (clk),
            .reset    (reset),
            .en       (en[g]),
            .dir      (dir[g]),
            .sat      (sat[g]),
            .load     (load[g]),
            .load_val (load_val[g*WIDTH +: WIDTH]),
            .count    (w_count[g*WIDTH +: WIDTH]),
            .tc       (tc[g])
        );
    end

    assign count = w_count;

`ifdef COUNTER_SNAPSHOT_EN
    logic [N_CH*WIDTH-1:0] r_snap_count;
    logic                  r_snap_valid;

    // Counts are registered, so sampling them here yields the pre-edge value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_snap_count <= '0;
            r_snap_valid <= 1'b0;
        end else begin
            r_snap_valid <= snap;
            if (snap) r_snap_count <= w_count;
        end
    end

    assign snap_count = r_snap_count;
    assign snap_valid = r_snap_valid;
`endif

endmodule

// File: tb/tb_multi_mode_counter.sv
// Directed-vector bench for multi_mode_counter (N_CH=2, WIDTH=8, MAX_VAL=9).
module tb_multi_mode_counter;

    localparam int N_CH  = 2;
    localparam int WIDTH = 8;

    logic                  clk;
    logic                  reset;
    logic [N_CH-1:0]       en;
    logic [N_CH-1:0]       dir;
    logic [N_CH-1:0]       sat;
    logic [N_CH-1:0]       load;
    logic [N_CH*WIDTH-1:0] load_val;
    logic [N_CH*WIDTH-1:0] count;
    logic [N_CH-1:0]       tc;
`ifdef COUNTER_SNAPSHOT_EN
    logic                  snap;
    logic [N_CH*WIDTH-1:0] snap_count;
    logic                  snap_valid;
`endif

    int n_vec;
    int n_err;

    multi_mode_counter #(
        .N_CH    (N_CH),
        .WIDTH   (WIDTH),
        .MAX_VAL (9),
        .RST_VAL (0)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .dir        (dir),
        .sat        (sat),
        .load       (load),
        .load_val   (load_val),
        .count      (count),
        .tc         (tc)
`ifdef COUNTER_SNAPSHOT_EN
        ,
        .snap       (snap),
        .snap_count (snap_count),
        .snap_valid (snap_valid)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(
        input string       tag,
        input logic [31:0] got,
        input logic [31:0] exp
    );
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] c0();
        return 32'(count[0 +: WIDTH]);
    endfunction

    function automatic logic [31:0] c1();
        return 32'(count[WIDTH +: WIDTH]);
    endfunction

    int up_exp[12]  = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
    int dn_exp[4]   = '{1, 0, 0, 0};
    int dn_tc[4]    = '{0, 0, 1, 1};

    initial begin
        int p0;
        int p1;
        n_vec    = 0;
        n_err    = 0;
        reset    = 1'b1;
        en       = '0;
        dir      = '0;
        sat      = '0;
        load     = '0;
        load_val = '0;
`ifdef COUNTER_SNAPSHOT_EN
        snap     = 1'b0;
`endif
        tick();
        tick();
        chk("rst_count", 32'(count), 0);
        chk("rst_tc", 32'(tc), 0);
`ifdef COUNTER_SNAPSHOT_EN
        chk("rst_snap_valid", 32'(snap_valid), 0);
        chk("rst_snap_count", 32'(snap_count), 0);
`endif
        #2 reset = 1'b0;

        // Mid-count asynchronous reset with ch0 at 5
        en  = 2'b01;
        dir = 2'b01;
        for (int i = 0; i < 5; i++) tick();
        chk("pre_rst_ch0", c0(), 5);
        en = '0;
        #2 reset = 1'b1;
        #1;
        chk("async_rst_ch0", c0(), 0);
        chk("async_rst_tc", 32'(tc), 0);
        #1 reset = 1'b0;
        tick();
        chk("post_rst_hold", c0(), 0);

        // ch0 up wrap, 12 clocks
        en  = 2'b01;
        dir = 2'b01;
        sat = 2'b00;
        for (int i = 0; i < 12; i++) begin
            tick();
            chk($sformatf("upwrap_cnt%0d", i), c0(), 32'(up_exp[i]));
            chk($sformatf("upwrap_tc%0d", i), 32'(tc[0]), (up_exp[i] == 0) ? 1 : 0);
        end
        chk("upwrap_ch1_idle", c1(), 0);
        en = '0;
        tick();
        chk("hold_ch0", c0(), 2);
        chk("hold_tc", 32'(tc), 0);

        // ch1 load 2 then down saturate
        load                    = 2'b10;
        load_val[WIDTH +: WIDTH] = 8'd2;
        tick();
        chk("dn_load", c1(), 2);
        load = '0;
        en   = 2'b10;
        dir  = 2'b00;
        sat  = 2'b10;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("dnsat_cnt%0d", i), c1(), 32'(dn_exp[i]));
            chk($sformatf("dnsat_tc%0d", i), 32'(tc[1]), 32'(dn_tc[i]));
        end
        en = '0;

        // Load beats enable and clamps to MAX_VAL
        en                 = 2'b01;
        dir                = 2'b01;
        sat                = 2'b00;
        load               = 2'b01;
        load_val[0 +: WIDTH] = 8'd200;
        tick();
        chk("clamp_cnt", c0(), 9);
        chk("clamp_tc", 32'(tc[0]), 0);
        load = '0;
        tick();
        chk("clamp_wrap_cnt", c0(), 0);
        chk("clamp_wrap_tc", 32'(tc[0]), 1);

        // Independence: ch0 up wrap, ch1 down wrap from 0
        en       = '0;
        load     = 2'b11;
        load_val = '0;
        tick();
        chk("ind_start", 32'(count), 0);
        load = '0;
        en   = 2'b11;
        dir  = 2'b01;
        sat  = 2'b00;
        p0   = 0;
        p1   = 0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            chk($sformatf("ind_c0_%0d", k), c0(), 32'(k % 10));
            chk($sformatf("ind_c1_%0d", k), c1(), 32'((10 - k) % 10));
            chk($sformatf("ind_tc1_%0d", k), 32'(tc[1]), (k == 1) ? 1 : 0);
            p0 += int'(tc[0]);
            p1 += int'(tc[1]);
        end
        chk("ind_pulses0", 32'(p0), 1);
        chk("ind_pulses1", 32'(p1), 1);
        en = '0;
        tick();
        chk("ind_end_tc", 32'(tc), 0);

`ifdef COUNTER_SNAPSHOT_EN
        load     = 2'b11;
        load_val = {8'd7, 8'd4};
        tick();
        load = '0;
        en   = 2'b11;
        dir  = 2'b11;
        snap = 1'b1;
        tick();
        chk("snap_count", 32'(snap_count), 32'({8'd7, 8'd4}));
        chk("snap_valid", 32'(snap_valid), 1);
        chk("snap_adv", 32'(count), 32'({8'd8, 8'd5}));
        snap = 1'b0;
        tick();
        chk("snap_valid_drop", 32'(snap_valid), 0);
        chk("snap_hold", 32'(snap_count), 32'({8'd7, 8'd4}));
        en = '0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
